// File: rtl/binary_to_bcd_converter_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM state encoding,
// the largest displayable value and the overflow nibble default.
package binary_to_bcd_converter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Largest value the four-digit display can show.
  localparam logic [31:0] BCD_MAX = 32'd9999;

  // Decoder dash code in decimal mode.
  localparam logic [3:0] OVF_CODE_DEF = 4'hA;

  // Leading-zero digit mask: units are always lit, and a higher digit is lit
  // when it or any digit above it is nonzero.
  function automatic logic [3:0] lz_mask(input logic [15:0] bcd);
    logic [3:0] m;
    m[3] = |bcd[15:12];
    m[2] = m[3] | (|bcd[11:8]);
    m[1] = m[2] | (|bcd[7:4]);
    m[0] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/binary_to_bcd_converter_add3_adjust.sv
// Double-dabble nibble correction: add 3 to any BCD nibble of 5 or more so
// that the following left shift carries correctly into the next digit.
module bcd_add3_adjust (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  // Pure combinational adjust.
  always_comb begin
    o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
  end

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble converter feeding the four-digit seven-segment
// decoder. One conversion takes IN_WIDTH shift cycles plus accept and
// output cycles. Values above 9999 render as dashes.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits;
// otherwise all four digits are enabled after every conversion.
module binary_to_bcd_converter
  import binary_to_bcd_converter_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 14,
  parameter logic [3:0]  OVF_CODE = OVF_CODE_DEF
) (
  input  logic                clk_100MHz,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] in_value,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [3:0]          v3,
  output logic [3:0]          v2,
  output logic [3:0]          v1,
  output logic [3:0]          v0,
  output logic [3:0]          digits,
  output logic                overflow,
  output logic                out_valid
);

  localparam int unsigned SR_W   = 16 + IN_WIDTH;
  localparam int unsigned ITER_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  bcd_state_t        r_state;
  logic [SR_W-1:0]   r_sh;
  logic [ITER_W-1:0] r_iter;
  logic              r_ovf;

  logic [SR_W-1:0]   w_adj;
  logic [15:0]       w_bcd;
  logic [3:0]        w_nib_in  [4];
  logic [3:0]        w_nib_out [4];

  // Split the BCD field of the shift register into its four digit nibbles.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      w_nib_in[k] = r_sh[IN_WIDTH + 4*k +: 4];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_adj
    bcd_add3_adjust u_adj (
      .i_nib (w_nib_in[g]),
      .o_nib (w_nib_out[g])
    );
  end

  // Reassemble the adjusted register ahead of the shift.
  always_comb begin
    w_adj = {w_nib_out[3], w_nib_out[2], w_nib_out[1], w_nib_out[0],
             r_sh[IN_WIDTH-1:0]};
    w_bcd = r_sh[SR_W-1 -: 16];
  end

  assign in_ready = (r_state == IDLE);

  // Control FSM, shift datapath and registered outputs.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sh      <= '0;
      r_iter    <= '0;
      r_ovf     <= 1'b0;
      v3        <= '0;
      v2        <= '0;
      v1        <= '0;
      v0        <= '0;
      digits    <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sh    <= {16'h0000, in_value};
            r_iter  <= '0;
            r_ovf   <= (32'(in_value) > BCD_MAX);
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sh   <= w_adj << 1;
          r_iter <= r_iter + ITER_W'(1);
          if (r_iter == ITER_W'(IN_WIDTH - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (r_ovf) begin
            v3     <= OVF_CODE;
            v2     <= OVF_CODE;
            v1     <= OVF_CODE;
            v0     <= OVF_CODE;
            digits <= 4'b1111;
          end else begin
            v3     <= w_bcd[15:12];
            v2     <= w_bcd[11:8];
            v1     <= w_bcd[7:4];
            v0     <= w_bcd[3:0];
`ifdef LEADING_ZERO_BLANK_EN
            digits <= lz_mask(w_bcd);
`else
            digits <= 4'b1111;
`endif
          end
          overflow  <= r_ovf;
          out_valid <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Directed testbench for binary_to_bcd_converter (default parameters).
// Expected digit masks follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_binary_to_bcd_converter;

  logic        clk_100MHz = 1'b0;
  logic        rst;
  logic [13:0] in_value;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  v3, v2, v1, v0;
  logic [3:0]  digits;
  logic        overflow;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  binary_to_bcd_converter #(.IN_WIDTH(14), .OVF_CODE(4'hA)) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .in_value   (in_value),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .v3         (v3),
    .v2         (v2),
    .v1         (v1),
    .v0         (v0),
    .digits     (digits),
    .overflow   (overflow),
    .out_valid  (out_valid)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_digits(input logic [3:0] lz);
`ifdef LEADING_ZERO_BLANK_EN
    return lz;
`else
    return (lz == lz) ? 4'b1111 : 4'b1111;
`endif
  endfunction

  // Single conversion: pulse in_valid, then check latency, busy window and result.
  task automatic run_conv(input string tag, input logic [13:0] val,
                          input logic [15:0] exp_v, input logic exp_ovf,
                          input logic [3:0] lz);
    int lat;
    int lows;
    @(negedge clk_100MHz);
    in_value = val;
    in_valid = 1'b1;
    @(posedge clk_100MHz);
    #1;
    in_valid = 1'b0;
    in_value = 14'h1555;
    lat  = 0;
    lows = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) lows++;
      @(posedge clk_100MHz);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 15);
    chk({tag, "_busy"}, lows, 15);
    chk({tag, "_value"}, {v3, v2, v1, v0}, exp_v);
    chk({tag, "_digits"}, digits, exp_digits(lz));
    chk({tag, "_ovf"}, overflow, exp_ovf);
    chk({tag, "_ready"}, in_ready, 1'b1);
    @(posedge clk_100MHz);
    #1;
    chk({tag, "_pulse"}, out_valid, 1'b0);
  endtask

  initial begin
    int pulses;
    int lat;
    rst      = 1'b1;
    in_value = '0;
    in_valid = 1'b0;
    #12;
    chk("rst_value", {v3, v2, v1, v0}, 16'h0000);
    chk("rst_digits", digits, 4'b0000);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_outvalid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    @(negedge clk_100MHz);
    rst = 1'b0;

    run_conv("c1234", 14'd1234, 16'h1234, 1'b0, 4'b1111);
    run_conv("c42", 14'd42, 16'h0042, 1'b0, 4'b0011);
    run_conv("c0", 14'd0, 16'h0000, 1'b0, 4'b0001);
    run_conv("c305", 14'd305, 16'h0305, 1'b0, 4'b0111);
    run_conv("c9999", 14'd9999, 16'h9999, 1'b0, 4'b1111);
    run_conv("c10000", 14'd10000, 16'hAAAA, 1'b1, 4'b1111);
    run_conv("c16383", 14'd16383, 16'hAAAA, 1'b1, 4'b1111);
    run_conv("c8000", 14'd8000, 16'h8000, 1'b0, 4'b1111);

    // Busy: in_valid held with 5678 during the 1234 conversion.
    @(negedge clk_100MHz);
    in_value = 14'd1234;
    in_valid = 1'b1;
    @(posedge clk_100MHz);
    #1;
    in_value = 14'd5678;
    pulses = 0;
    lat = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk_100MHz);
      #1;
      if (out_valid) begin
        pulses++;
        lat = i;
      end
    end
    chk("busy_value", {v3, v2, v1, v0}, 16'h1234);
    chk("busy_pulses", pulses, 1);
    chk("busy_latency", lat, 15);
    chk("busy_ready", in_ready, 1'b1);
    @(posedge clk_100MHz);
    #1;
    chk("busy_accept2", in_ready, 1'b0);
    chk("busy_pulse_end", out_valid, 1'b0);
    in_valid = 1'b0;
    in_value = 14'd3;
    pulses = 0;
    lat = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk_100MHz);
      #1;
      if (out_valid) begin
        pulses++;
        lat = i;
      end
    end
    chk("second_value", {v3, v2, v1, v0}, 16'h5678);
    chk("second_digits", digits, 4'b1111);
    chk("second_pulses", pulses, 1);
    chk("second_latency", lat, 15);

    // Reset mid-conversion discards the result.
    @(negedge clk_100MHz);
    in_value = 14'd4321;
    in_valid = 1'b1;
    @(posedge clk_100MHz);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk_100MHz);
    rst = 1'b1;
    #1;
    chk("midrst_value", {v3, v2, v1, v0}, 16'h0000);
    chk("midrst_digits", digits, 4'b0000);
    chk("midrst_ready", in_ready, 1'b1);
    @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_100MHz);
      #1;
      if (out_valid) pulses++;
    end
    chk("midrst_nopulse", pulses, 0);
    chk("midrst_hold", {v3, v2, v1, v0}, 16'h0000);
    run_conv("c777", 14'd777, 16'h0777, 1'b0, 4'b0111);

    // Back-to-back ascending powers of ten.
    run_conv("b0", 14'd0, 16'h0000, 1'b0, 4'b0001);
    run_conv("b1", 14'd1, 16'h0001, 1'b0, 4'b0001);
    run_conv("b10", 14'd10, 16'h0010, 1'b0, 4'b0011);
    run_conv("b100", 14'd100, 16'h0100, 1'b0, 4'b0111);
    run_conv("b1000", 14'd1000, 16'h1000, 1'b0, 4'b1111);

    // Outputs hold while idle.
    repeat (5) @(posedge clk_100MHz);
    #1;
    chk("idle_hold", {v3, v2, v1, v0}, 16'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
